// File: rtl/operand_loader.sv
// ============================================================================
// Module   : operand_loader
// Purpose  : Serial-to-parallel loader that assembles two 4-bit operands
//            (A then B, MSB first) after a start request.
//            Optional even parity per operand: OPERAND_LOADER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       din,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       valid,
    output logic       busy
`ifdef OPERAND_LOADER_PARITY_EN
    ,
    output logic       err
`endif
);

`ifdef OPERAND_LOADER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        PAR_A  = 3'd3,
        PAR_B  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2
    } state_t;
`endif

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic [3:0] r_sh_a;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_valid;
    logic       w_last_bit;
    logic       w_in_load;

`ifdef OPERAND_LOADER_PARITY_EN
    logic [3:0] r_sh_b;
    logic       r_a_bad;
    logic       r_err;
    logic       w_b_bad;
`else
    // The last B bit goes straight from din into b, so only 3 bits are held.
    logic [2:0] r_sh_b;
    logic       w_done;
`endif

    assign w_last_bit = (r_cnt == 2'd3);
    assign w_in_load  = (r_state == LOAD_A) || (r_state == LOAD_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
`ifdef OPERAND_LOADER_PARITY_EN
        w_b_bad      = ^{r_sh_b, din};
`else
        w_done       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (start) w_next_state = LOAD_A;
            end
            LOAD_A: begin
`ifdef OPERAND_LOADER_PARITY_EN
                if (w_last_bit) w_next_state = PAR_A;
`else
                if (w_last_bit) w_next_state = LOAD_B;
`endif
            end
            LOAD_B: begin
                if (w_last_bit) begin
`ifdef OPERAND_LOADER_PARITY_EN
                    w_next_state = PAR_B;
`else
                    w_next_state = IDLE;
                    w_done       = 1'b1;
`endif
                end
            end
`ifdef OPERAND_LOADER_PARITY_EN
            PAR_A: w_next_state = LOAD_B;
            PAR_B: w_next_state = IDLE;
`endif
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_sh_a  <= 4'd0;
            r_sh_b  <= '0;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_valid <= 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
            r_a_bad <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            // Counter runs only inside a load state and restarts on any state change.
            if (w_in_load && (w_next_state == r_state)) begin
                r_cnt <= r_cnt + 2'd1;
            end else begin
                r_cnt <= 2'd0;
            end
            if (r_state == LOAD_A) r_sh_a <= {r_sh_a[2:0], din};
`ifdef OPERAND_LOADER_PARITY_EN
            r_err <= 1'b0;
            if (r_state == LOAD_B) r_sh_b <= {r_sh_b[2:0], din};
            if (r_state == PAR_A)  r_a_bad <= ^{r_sh_a, din};
            if (r_state == PAR_B) begin
                if (r_a_bad || w_b_bad) begin
                    r_err <= 1'b1;
                end else begin
                    r_a     <= r_sh_a;
                    r_b     <= r_sh_b;
                    r_valid <= 1'b1;
                end
            end
`else
            if (r_state == LOAD_B) r_sh_b <= {r_sh_b[1:0], din};
            if (w_done) begin
                r_a     <= r_sh_a;
                r_b     <= {r_sh_b, din};
                r_valid <= 1'b1;
            end
`endif
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);
`ifdef OPERAND_LOADER_PARITY_EN
    assign err   = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module   : tb_operand_loader
// Purpose  : Directed, scoreboard-based bench for operand_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       din;
    logic [3:0] a;
    logic [3:0] b;
    logic       valid;
    logic       busy;
`ifdef OPERAND_LOADER_PARITY_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nvalid   = 0;
    logic [7:0] exp_q[$];
    int         vcyc_q[$];
    logic [3:0] model_a = 4'd0;
    logic [3:0] model_b = 4'd0;

    operand_loader dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (din),
        .a     (a),
        .b     (b),
        .valid (valid),
        .busy  (busy)
`ifdef OPERAND_LOADER_PARITY_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: each valid pulse must match the oldest pushed {a,b}.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            nvalid++;
            vcyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 8'd1, 8'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("sb_a", {4'd0, a}, {4'd0, e[7:4]});
                chk("sb_b", {4'd0, b}, {4'd0, e[3:0]});
            end
        end
    end

    // Drives start then A, [pa], B, [pb]; poke>=0 pulses start on that B bit.
    // Returns 1ns after the final edge, i.e. inside the valid cycle.
    task automatic drive_frame(input logic [3:0] av, input logic [3:0] bv,
                               input int poke, input logic pa, input logic pb);
        start = 1'b1;
        din   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_k", {7'd0, busy}, 8'd1);
        for (int i = 3; i >= 0; i--) begin
            din = av[i];
            @(posedge clk); #1;
            chk("busy_a", {7'd0, busy}, 8'd1);
            chk("hold_a", {a, b}, {model_a, model_b});
        end
`ifdef OPERAND_LOADER_PARITY_EN
        din = pa;
        @(posedge clk); #1;
        chk("busy_pa", {7'd0, busy}, 8'd1);
`endif
        for (int i = 3; i >= 0; i--) begin
            din   = bv[i];
            start = (i == poke);
`ifdef OPERAND_LOADER_PARITY_EN
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy_b", {7'd0, busy}, 8'd1);
        end
        din = pb;
        @(posedge clk); #1;
`else
            @(posedge clk); #1;
            start = 1'b0;
            if (i != 0) chk("busy_b", {7'd0, busy}, 8'd1);
        end
`endif
        chk("busy_end", {7'd0, busy}, 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int nv0;
        reset = 1'b1;
        start = 1'b1;
        din   = 1'b0;
        idle(3);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_ab", {a, b}, 8'h00);
            chk("idle_vb", {6'd0, valid, busy}, 8'd0);
        end

`ifndef OPERAND_LOADER_PARITY_EN
        // Basic frame (4,F)
        exp_q.push_back(8'h4F);
        drive_frame(4'h4, 4'hF, -1, 1'b0, 1'b0);
        chk("f1_valid", {7'd0, valid}, 8'd1);
        chk("f1_ab", {a, b}, 8'h4F);
        model_a = 4'h4; model_b = 4'hF;
        idle(1);
        chk("f1_valid_off", {7'd0, valid}, 8'd0);

        // Back-to-back (4,7) then (4,F)
        idle(2);
        vcyc_q.delete();
        exp_q.push_back(8'h47);
        exp_q.push_back(8'h4F);
        drive_frame(4'h4, 4'h7, -1, 1'b0, 1'b0);
        model_a = 4'h4; model_b = 4'h7;
        drive_frame(4'h4, 4'hF, -1, 1'b0, 1'b0);
        model_a = 4'h4; model_b = 4'hF;
        idle(1);
        chk("b2b_pulses", vcyc_q.size(), 8'd2);
        if (vcyc_q.size() == 2) chk("b2b_gap", vcyc_q[1] - vcyc_q[0], 8'd9);

        // start poked during LOAD_B must be ignored
        idle(2);
        nv0 = nvalid;
        exp_q.push_back(8'h47);
        drive_frame(4'h4, 4'h7, 2, 1'b0, 1'b0);
        model_a = 4'h4; model_b = 4'h7;
        idle(14);
        chk("poke_pulses", nvalid - nv0, 8'd1);
        chk("poke_ab", {a, b}, 8'h47);
        chk("poke_idle", {7'd0, busy}, 8'd0);

        // Reset at edge k+3 of (4,F) discards the frame and clears a/b
        nv0 = nvalid;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din = 1'b0; @(posedge clk); #1;
        din = 1'b1; @(posedge clk); #1;
        reset = 1'b1;
        din = 1'b0; @(posedge clk); #1;
        reset = 1'b0;
        model_a = 4'h0; model_b = 4'h0;
        chk("mid_rst_ab", {a, b}, 8'h00);
        chk("mid_rst_busy", {6'd0, valid, busy}, 8'd0);
        idle(12);
        chk("mid_rst_nov", nvalid - nv0, 8'd0);
        exp_q.push_back(8'h47);
        drive_frame(4'h4, 4'h7, -1, 1'b0, 1'b0);
        chk("post_rst_ab", {a, b}, 8'h47);
        idle(2);
`else
        // Good parity frame: 0100 p=1, 1111 p=0
        exp_q.push_back(8'h4F);
        drive_frame(4'h4, 4'hF, -1, 1'b1, 1'b0);
        chk("par_valid", {6'd0, valid, err}, 8'h2);
        chk("par_ab", {a, b}, 8'h4F);
        model_a = 4'h4; model_b = 4'hF;
        idle(2);
        // A parity flipped: err only, a/b retained
        nv0 = nvalid;
        drive_frame(4'h2, 4'h3, -1, 1'b0, 1'b0);
        chk("perr_flags", {6'd0, valid, err}, 8'h1);
        chk("perr_ab", {a, b}, 8'h4F);
        idle(1);
        chk("perr_off", {7'd0, err}, 8'd0);
        chk("perr_nov", nvalid - nv0, 8'd0);
`endif

        chk("sb_empty", exp_q.size(), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to begin one operand frame; honoured only when busy=0.
REQ-005 din  input  1  serial data bit, MSB first, sampled on rising clk.
REQ-006 a  output  4  assembled operand A, registered, for the downstream comparator.
REQ-007 b  output  4  assembled operand B, registered, for the downstream comparator.
REQ-008 valid  output  1  one-cycle pulse: a/b hold a new frame.
REQ-009 busy  output  1  high while a frame is being received.
REQ-010 err  output  1  one-cycle parity-error pulse; present only with OPERAND_LOADER_PARITY_EN.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD_A, LOAD_B and, when the macro is defined, PAR_A and PAR_B.
- IDLE: start=1 -> LOAD_A; otherwise stay.
- LOAD_A: after 4 bits -> PAR_A (macro) or LOAD_B.
- PAR_A: after 1 bit -> LOAD_B.
- LOAD_B: after 4 bits -> PAR_B (macro) or IDLE.
- PAR_B: after 1 bit -> IDLE.
REQ-012 The edge that samples start=1 (edge k) SHALL carry no data; din is ignored on that edge.
REQ-013 Without the macro, din on edges k+1..k+4 SHALL form A[3:0] and on edges k+5..k+8 SHALL form B[3:0], MSB first.
REQ-014 A 2-bit bit counter SHALL count within LOAD_A and LOAD_B and SHALL wrap to 0 on each state change.
REQ-015 Shift registers SHALL be internal; a and b SHALL change only on the final edge of a frame, both on the same edge, never with partial data.
REQ-016 On the final edge of a good frame, the block SHALL update a and b and drive valid=1 for exactly one cycle.
- Final edge = k+8 without the macro, k+10 with it.
REQ-017 busy SHALL be 1 from edge k through the final edge, and 0 in IDLE, including the valid cycle.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 start=1 during the valid cycle SHALL be accepted as edge k of the next frame, giving back-to-back frames with no gap.
REQ-020 Operand bits SHALL be stored raw; interpretation as signed or unsigned belongs to the consumer (4'b1111 = -1 or 15).

Reset
REQ-021 reset=1 SHALL force, on the next rising clk: state IDLE, counter 0, shift registers 0, a=0, b=0, valid=0, busy=0, err=0.
REQ-022 reset SHALL take priority over start and over any in-progress frame.
REQ-023 A reset during a frame SHALL discard the partial frame; a and b SHALL NOT be updated from it.
REQ-024 start sampled in the same cycle as reset=1 SHALL be ignored.

Configuration
REQ-025 The macro OPERAND_LOADER_PARITY_EN SHALL compile the parity feature in or out.
REQ-026 When OPERAND_LOADER_PARITY_EN is defined:
- one even-parity bit SHALL follow each operand (edge k+5 after A, edge k+10 after B);
- the XOR of the 4 data bits and the parity bit SHALL equal 0 for a good operand.
REQ-027 When OPERAND_LOADER_PARITY_EN is defined and either operand fails parity:
- on edge k+10, err=1 for one cycle and valid stays 0;
- a and b SHALL retain their previous values;
- the FSM SHALL return to IDLE.
REQ-028 When OPERAND_LOADER_PARITY_EN is undefined, there SHALL be no err port and no PAR states, and the frame SHALL be 9 edges (k..k+8).

Verification
REQ-029 Reset then idle 100 ns -> a=0, b=0, valid=0, busy=0 throughout.
REQ-030 start at edge k, din 0100 then 1111 (no macro) -> at edge k+8: a=4'h4, b=4'hF, valid=1 for one cycle; busy=1 for edges k..k+7.
REQ-031 Back-to-back frames (4,7) then (4,15), second start during the first valid cycle -> two valid pulses 9 cycles apart; a=4 both times; b=7 then 15.
REQ-032 start pulsed during LOAD_B of a frame (4,7) -> that start is ignored; a=4, b=7; exactly one valid pulse.
REQ-033 reset asserted at edge k+3 of frame (4,15) -> a=0, b=0, no valid pulse; a fresh frame (4,7) then completes normally.
REQ-034 With the macro, frame 0100,p=1,1111,p=0 -> valid=1, a=4, b=15; repeat with A parity flipped -> err=1, valid=0, a=4 and b=15 retained.
